// File: rtl/nvdla_ram_fifo_ctrl.sv
// nvdla_ram_fifo_ctrl
//   Valid/ready FIFO controller in front of an external two-port RAM macro
//   with a two-stage read port (address register on ram_re, output register
//   on ram_ore). The consumer reads straight from the macro output register.
//
//   Optional build macro: NVDLA_RAM_FIFO_BYPASS_EN
//     When defined, a write arriving at an otherwise empty pipe is steered
//     through the macro bypass path directly into the output register.
//     When undefined, ram_byp_sel and ram_dbyp are tied low.

module nvdla_ram_fifo_ctrl #(
  parameter int unsigned DEPTH = 80,
  parameter int unsigned AW    = 7,
  parameter int unsigned DW    = 15
) (
  input  logic          nvdla_core_clk,
  input  logic          nvdla_core_rstn,
  input  logic          wr_pvld,
  output logic          wr_prdy,
  input  logic [DW-1:0] wr_pd,
  output logic          rd_pvld,
  input  logic          rd_prdy,
  output logic [DW-1:0] rd_pd,
  output logic [AW:0]   fifo_used,
  output logic          ram_we,
  output logic [AW-1:0] ram_wa,
  output logic [DW-1:0] ram_di,
  output logic          ram_re,
  output logic [AW-1:0] ram_ra,
  output logic          ram_ore,
  input  logic [DW-1:0] ram_dout,
  output logic          ram_byp_sel,
  output logic [DW-1:0] ram_dbyp,
  input  logic [31:0]   pwrbus_ram_pd_in,
  output logic [31:0]   pwrbus_ram_pd
);

  localparam logic [AW:0]   CNT_DEPTH = (AW+1)'(DEPTH);
  localparam logic [AW:0]   CNT_ONE   = (AW+1)'(1);
  localparam logic [AW-1:0] PTR_LAST  = AW'(DEPTH - 1);
  localparam logic [AW-1:0] PTR_ONE   = AW'(1);

  // State registers
  logic [AW-1:0] wr_ptr_q, wr_ptr_d;
  logic [AW-1:0] rd_ptr_q, rd_ptr_d;
  logic [AW:0]   used_q,   used_d;    // committed writes not yet in output register
  logic [AW:0]   avail_q,  avail_d;   // committed writes not yet read-issued
  logic          s1_vld_q, s1_vld_d;  // macro address register holds a live address
  logic          s2_vld_q, s2_vld_d;  // macro output register holds live data

  // Datapath control
  logic wr_accept;   // producer handshake that lands in the RAM
  logic rd_issue;    // read address launched into the macro
  logic stage_adv;   // RAM data moved into the macro output register
  logic byp_fire;    // producer data sent through the bypass path
  logic rd_take;     // consumer handshake

  // Bypass path: only legal when the RAM and address stage are empty and
  // the output register is free to load this cycle.
`ifdef NVDLA_RAM_FIFO_BYPASS_EN
  assign byp_fire    = (used_q == '0) & ~s1_vld_q & (~s2_vld_q | rd_prdy) & wr_pvld;
  assign ram_byp_sel = byp_fire;
  assign ram_dbyp    = byp_fire ? wr_pd : '0;
`else
  assign byp_fire    = 1'b0;
  assign ram_byp_sel = 1'b0;
  assign ram_dbyp    = '0;
`endif

  // Handshake and RAM port strobes
  always_comb begin
    wr_prdy   = (used_q < CNT_DEPTH);
    wr_accept = wr_pvld & wr_prdy & ~byp_fire;
    stage_adv = s1_vld_q & (~s2_vld_q | rd_prdy);
    rd_issue  = (avail_q != '0) & (~s1_vld_q | stage_adv);
    rd_take   = s2_vld_q & rd_prdy;
  end

  assign ram_we        = wr_accept;
  assign ram_wa        = wr_ptr_q;
  assign ram_di        = wr_pd;
  assign ram_re        = rd_issue;
  assign ram_ra        = rd_ptr_q;
  assign ram_ore       = stage_adv | byp_fire;
  assign rd_pvld       = s2_vld_q;
  assign rd_pd         = ram_dout;
  assign fifo_used     = used_q;
  assign pwrbus_ram_pd = pwrbus_ram_pd_in;

  // Pointer advance with wrap at DEPTH-1 (DEPTH need not be a power of two)
  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    if (wr_accept) begin
      wr_ptr_d = (wr_ptr_q == PTR_LAST) ? '0 : wr_ptr_q + PTR_ONE;
    end
    if (rd_issue) begin
      rd_ptr_d = (rd_ptr_q == PTR_LAST) ? '0 : rd_ptr_q + PTR_ONE;
    end
  end

  // Occupancy counters; a slot is freed only once its data has been captured
  always_comb begin
    used_d  = used_q;
    avail_d = avail_q;
    unique case ({wr_accept, stage_adv})
      2'b10:   used_d = used_q + CNT_ONE;
      2'b01:   used_d = used_q - CNT_ONE;
      default: used_d = used_q;
    endcase
    unique case ({wr_accept, rd_issue})
      2'b10:   avail_d = avail_q + CNT_ONE;
      2'b01:   avail_d = avail_q - CNT_ONE;
      default: avail_d = avail_q;
    endcase
  end

  // Read pipeline stage valids
  always_comb begin
    s1_vld_d = s1_vld_q;
    s2_vld_d = s2_vld_q;
    if (rd_issue) begin
      s1_vld_d = 1'b1;
    end else if (stage_adv) begin
      s1_vld_d = 1'b0;
    end
    if (ram_ore) begin
      s2_vld_d = 1'b1;
    end else if (rd_take) begin
      s2_vld_d = 1'b0;
    end
  end

  // State update; reset discards all stored and in-flight entries
  always_ff @(posedge nvdla_core_clk or negedge nvdla_core_rstn) begin
    if (!nvdla_core_rstn) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      used_q   <= '0;
      avail_q  <= '0;
      s1_vld_q <= 1'b0;
      s2_vld_q <= 1'b0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      used_q   <= used_d;
      avail_q  <= avail_d;
      s1_vld_q <= s1_vld_d;
      s2_vld_q <= s2_vld_d;
    end
  end

endmodule

// File: tb/tb_nvdla_ram_fifo_ctrl.sv
// Testbench for nvdla_ram_fifo_ctrl: behavioural RAM macro plus an in-order
// queue reference model of the FIFO contents.
module tb_nvdla_ram_fifo_ctrl;

  localparam int DEPTH = 80;
  localparam int AW    = 7;
  localparam int DW    = 15;
`ifdef NVDLA_RAM_FIFO_BYPASS_EN
  localparam int LAT   = 1;
  localparam logic BYP = 1'b1;
`else
  localparam int LAT   = 3;
  localparam logic BYP = 1'b0;
`endif

  logic          clk;
  logic          rstn;
  logic          wr_pvld;
  logic          wr_prdy;
  logic [DW-1:0] wr_pd;
  logic          rd_pvld;
  logic          rd_prdy;
  logic [DW-1:0] rd_pd;
  logic [AW:0]   fifo_used;
  logic          ram_we;
  logic [AW-1:0] ram_wa;
  logic [DW-1:0] ram_di;
  logic          ram_re;
  logic [AW-1:0] ram_ra;
  logic          ram_ore;
  logic [DW-1:0] ram_dout;
  logic          ram_byp_sel;
  logic [DW-1:0] ram_dbyp;
  logic [31:0]   pwr_val;
  logic [31:0]   pwrbus_ram_pd;

  nvdla_ram_fifo_ctrl #(.DEPTH(DEPTH), .AW(AW), .DW(DW)) dut (
    .nvdla_core_clk   (clk),
    .nvdla_core_rstn  (rstn),
    .wr_pvld          (wr_pvld),
    .wr_prdy          (wr_prdy),
    .wr_pd            (wr_pd),
    .rd_pvld          (rd_pvld),
    .rd_prdy          (rd_prdy),
    .rd_pd            (rd_pd),
    .fifo_used        (fifo_used),
    .ram_we           (ram_we),
    .ram_wa           (ram_wa),
    .ram_di           (ram_di),
    .ram_re           (ram_re),
    .ram_ra           (ram_ra),
    .ram_ore          (ram_ore),
    .ram_dout         (ram_dout),
    .ram_byp_sel      (ram_byp_sel),
    .ram_dbyp         (ram_dbyp),
    .pwrbus_ram_pd_in (pwr_val),
    .pwrbus_ram_pd    (pwrbus_ram_pd)
  );

  // Behavioural two-stage-read RAM macro
  logic [DW-1:0] mem [0:(1<<AW)-1];
  logic [AW-1:0] ra_q;
  logic [DW-1:0] dout_q;
  assign ram_dout = dout_q;

  always @(posedge clk) begin
    if (ram_we) mem[ram_wa] <= ram_di;
    if (ram_re) ra_q <= ram_ra;
    if (ram_ore) dout_q <= ram_byp_sel ? ram_dbyp : mem[ra_q];
  end

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit expired");
    $fatal(1, "watchdog");
  end

  int n_asrt = 0;
  int n_fail = 0;
  int cyc = 0;
  int n_wr = 0;
  int n_rd = 0;
  int first_pop = -1;
  int last_pop = -1;
  logic [DW-1:0] exp_q[$];

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_asrt++;
    assert (got === exp) else begin
      n_fail++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  // One clock cycle: sample mid-cycle, update the reference model, advance.
  task automatic tick();
    #4;
    chk("pwrbus", pwrbus_ram_pd, pwr_val);
    chk("ram_di", 32'(ram_di), 32'(wr_pd));
    chk("used_bound", 32'(fifo_used <= 8'(DEPTH)), 32'd1);
`ifndef NVDLA_RAM_FIFO_BYPASS_EN
    chk("byp_sel_tied", 32'(ram_byp_sel), 32'd0);
    chk("dbyp_tied", 32'(ram_dbyp), 32'd0);
`endif
    if (rd_pvld === 1'b1) begin
      if (exp_q.size() == 0) begin
        chk("rd_model_nonempty", 32'(exp_q.size() != 0), 32'd1);
      end else begin
        chk("rd_pd", 32'(rd_pd), 32'(exp_q[0]));
      end
      if (rd_prdy) begin
        if (exp_q.size() != 0) void'(exp_q.pop_front());
        n_rd++;
        last_pop = cyc;
        if (first_pop < 0) first_pop = cyc;
      end
    end
    if (wr_pvld && wr_prdy === 1'b1) begin
      exp_q.push_back(wr_pd);
      n_wr++;
    end
    @(posedge clk);
    #1;
    cyc++;
  endtask

  initial begin
    int t0;
    rstn    = 1'b0;
    wr_pvld = 1'b0;
    wr_pd   = '0;
    rd_prdy = 1'b0;
    pwr_val = $urandom;
    repeat (3) @(posedge clk);
    #1;
    chk("rst_wr_prdy", 32'(wr_prdy), 32'd1);
    chk("rst_rd_pvld", 32'(rd_pvld), 32'd0);
    chk("rst_ram_re", 32'(ram_re), 32'd0);
    chk("rst_ram_ore", 32'(ram_ore), 32'd0);
    chk("rst_used", 32'(fifo_used), 32'd0);
    chk("rst_ram_we", 32'(ram_we), 32'd0);
    rstn = 1'b1;
    repeat (6) tick();

    // Single write latency
    rd_prdy = 1'b1;
    n_rd = 0;
    first_pop = -1;
    wr_pvld = 1'b1;
    wr_pd = 15'h1A5;
    t0 = cyc;
    tick();
    wr_pvld = 1'b0;
    repeat (8) tick();
    chk("single_count", 32'(n_rd), 32'd1);
    chk("single_latency", 32'(first_pop - t0), 32'(LAT));
    chk("single_used", 32'(fifo_used), 32'd0);

    // Fill to full with the consumer stalled
    rd_prdy = 1'b0;
    n_wr = 0;
    n_rd = 0;
    wr_pvld = 1'b1;
    for (int i = 0; i < 120; i++) begin
      if (wr_prdy !== 1'b1) break;
      wr_pd = 15'(n_wr);
      tick();
    end
    chk("full_accepts", 32'(n_wr), 32'(DEPTH + 1));
    chk("full_used", 32'(fifo_used), 32'(DEPTH));
    chk("full_prdy", 32'(wr_prdy), 32'd0);
    wr_pd = 15'(n_wr);
    rd_prdy = 1'b1;
    tick();
    rd_prdy = 1'b0;
    chk("pop_one_count", 32'(n_rd), 32'd1);
    chk("prdy_after_pop", 32'(wr_prdy), 32'd1);
    tick();
    chk("accept_after_pop", 32'(n_wr), 32'(DEPTH + 2));
    wr_pvld = 1'b0;
    rd_prdy = 1'b1;
    for (int i = 0; i < 300 && exp_q.size() != 0; i++) tick();
    repeat (4) tick();
    chk("full_drain_q", 32'(exp_q.size()), 32'd0);
    chk("full_drain_rd", 32'(n_rd), 32'(DEPTH + 2));
    chk("full_drain_used", 32'(fifo_used), 32'd0);
    chk("full_drain_pvld", 32'(rd_pvld), 32'd0);

    // Back-to-back stream across pointer wrap
    n_wr = 0;
    n_rd = 0;
    first_pop = -1;
    rd_prdy = 1'b1;
    wr_pvld = 1'b1;
    for (int i = 0; i < 300; i++) begin
      wr_pd = 15'(16'h0100 + i);
      tick();
    end
    wr_pvld = 1'b0;
    for (int i = 0; i < 50 && exp_q.size() != 0; i++) tick();
    chk("tput_wr", 32'(n_wr), 32'd300);
    chk("tput_rd", 32'(n_rd), 32'd300);
    chk("tput_no_gap", 32'(last_pop - first_pop + 1), 32'd300);
    chk("tput_used", 32'(fifo_used), 32'd0);

    // Random producer/consumer traffic
    n_wr = 0;
    n_rd = 0;
    for (int i = 0; i < 20000 && n_rd < 1000; i++) begin
      wr_pvld = (n_wr < 1000) && ($urandom_range(0, 9) < 7);
      wr_pd   = 15'($urandom);
      rd_prdy = 1'($urandom_range(0, 1));
      if ($urandom_range(0, 31) == 0) pwr_val = $urandom;
      tick();
    end
    wr_pvld = 1'b0;
    rd_prdy = 1'b1;
    repeat (4) tick();
    chk("rand_wr", 32'(n_wr), 32'd1000);
    chk("rand_rd", 32'(n_rd), 32'd1000);
    chk("rand_q_empty", 32'(exp_q.size()), 32'd0);
    chk("rand_used", 32'(fifo_used), 32'd0);

    // Reset with stored entries and both read stages loaded
    rd_prdy = 1'b0;
    n_wr = 0;
    wr_pvld = 1'b1;
    for (int i = 0; i < 100 && n_wr < 40; i++) begin
      wr_pd = 15'($urandom);
      tick();
    end
    wr_pvld = 1'b0;
    repeat (4) tick();
    chk("pre_rst_pvld", 32'(rd_pvld), 32'd1);
    chk("pre_rst_used", 32'(fifo_used), 32'd39);
    #2;
    rstn = 1'b0;
    #1;
    chk("mid_rst_pvld", 32'(rd_pvld), 32'd0);
    chk("mid_rst_used", 32'(fifo_used), 32'd0);
    chk("mid_rst_prdy", 32'(wr_prdy), 32'd1);
    chk("mid_rst_re", 32'(ram_re), 32'd0);
    chk("mid_rst_ore", 32'(ram_ore), 32'd0);
    exp_q.delete();
    @(posedge clk);
    #1;
    rstn = 1'b1;
    tick();
    n_rd = 0;
    rd_prdy = 1'b1;
    wr_pvld = 1'b1;
    wr_pd = 15'h2B3C;
    #1;
    chk("post_rst_we", 32'(ram_we), 32'(!BYP));
    chk("post_rst_wa", 32'(ram_wa), 32'd0);
    tick();
    for (int i = 0; i < 5; i++) begin
      wr_pd = 15'($urandom);
      tick();
    end
    wr_pvld = 1'b0;
    repeat (8) tick();
    chk("post_rst_rd", 32'(n_rd), 32'd6);
    chk("post_rst_q", 32'(exp_q.size()), 32'd0);

`ifdef NVDLA_RAM_FIFO_BYPASS_EN
    // Alternating write/pop on an empty FIFO uses only the bypass path
    rd_prdy = 1'b1;
    for (int i = 0; i < 8; i++) begin
      wr_pvld = 1'b1;
      wr_pd = 15'($urandom);
      #1;
      chk("byp_sel", 32'(ram_byp_sel), 32'd1);
      chk("byp_we", 32'(ram_we), 32'd0);
      chk("byp_ore", 32'(ram_ore), 32'd1);
      chk("byp_dbyp", 32'(ram_dbyp), 32'(wr_pd));
      tick();
      wr_pvld = 1'b0;
      chk("byp_pvld", 32'(rd_pvld), 32'd1);
      tick();
    end
    chk("byp_used", 32'(fifo_used), 32'd0);
`endif

    $display("End of test - %0d assertions evaluated, %0d failures", n_asrt, n_fail);
    $finish;
  end

endmodule
